// File: rtl/dpram_pkg.sv
// Shared constants and helpers for the pipelined dual-port RAM.
// Holds the read-latency ceiling and the lane-count helper.
package dpram_pkg;

    localparam int MAX_RD_LATENCY = 3;

    function automatic int calc_lanes(input int bitsize, input int lane_width);
        return bitsize / lane_width;
    endfunction

endpackage

// File: rtl/dpram_rd_pipe.sv
// Read-result delay line: DEPTH register stages of {valid, err, data}.
// Ports: clk, rst (sync, active-high), i_valid/i_err/i_data in, o_* out.
// Data registers only load on a valid beat, so the tail holds the last
// delivered word; valid/err are cleared on reset, data is zeroed.
module dpram_rd_pipe
    import dpram_pkg::*;
#(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_err,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_err,
    output logic [WIDTH-1:0] o_data
);

    if (DEPTH < 0 || DEPTH > MAX_RD_LATENCY - 1) begin : g_bad_depth
        $error("dpram_rd_pipe: illegal DEPTH");
    end

    if (DEPTH == 0) begin : g_bypass
        assign o_valid = i_valid;
        assign o_err   = i_err;
        assign o_data  = i_data;
    end else begin : g_pipe
        logic             r_valid [DEPTH];
        logic             r_err   [DEPTH];
        logic [WIDTH-1:0] r_data  [DEPTH];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < DEPTH; k++) begin
                    r_valid[k] <= 1'b0;
                    r_err[k]   <= 1'b0;
                    r_data[k]  <= '0;
                end
            end else begin
                r_valid[0] <= i_valid;
                r_err[0]   <= i_valid & i_err;
                if (i_valid) r_data[0] <= i_data;
                for (int k = 1; k < DEPTH; k++) begin
                    r_valid[k] <= r_valid[k-1];
                    r_err[k]   <= r_valid[k-1] & r_err[k-1];
                    if (r_valid[k-1]) r_data[k] <= r_data[k-1];
                end
            end
        end

        assign o_valid = r_valid[DEPTH-1];
        assign o_err   = r_err[DEPTH-1];
        assign o_data  = r_data[DEPTH-1];
    end

endmodule

// File: rtl/pipelined_dual_port_ram.sv
// Pipelined dual-port RAM: one lane-masked write port, one read port
// with RD_LATENCY-cycle fully pipelined reads and out-of-range flag.
// Ports: clk, rst (sync, active-high); write/wbe/wadrs/wdata;
//        read/radrs; rdata/rvalid/rerr.
// Macro DPRAM_BYPASS_EN: same-cycle same-address read returns the
// merged (post-write) word; undefined returns the pre-write word.
module pipelined_dual_port_ram
    import dpram_pkg::*;
#(
    parameter  int BITSIZE      = 32,
    parameter  int LANE_WIDTH   = 8,
    parameter  int MEMSIZE      = 48,
    parameter  int ADDRESS_SIZE = 6,
    parameter  int RD_LATENCY   = 2,
    localparam int LANES        = calc_lanes(BITSIZE, LANE_WIDTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    write,
    input  logic [LANES-1:0]        wbe,
    input  logic [ADDRESS_SIZE-1:0] wadrs,
    input  logic [BITSIZE-1:0]      wdata,
    input  logic                    read,
    input  logic [ADDRESS_SIZE-1:0] radrs,
    output logic [BITSIZE-1:0]      rdata,
    output logic                    rvalid,
    output logic                    rerr
);

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_lat
        $error("pipelined_dual_port_ram: illegal RD_LATENCY");
    end
    if (MEMSIZE < 1 || MEMSIZE > (2 ** ADDRESS_SIZE)) begin : g_bad_mem
        $error("pipelined_dual_port_ram: illegal MEMSIZE");
    end
    if (LANE_WIDTH < 1 || (BITSIZE % LANE_WIDTH) != 0) begin : g_bad_lane
        $error("pipelined_dual_port_ram: BITSIZE not a multiple of LANE_WIDTH");
    end

    // One extra bit so MEMSIZE == 2**ADDRESS_SIZE compares correctly.
    localparam logic [ADDRESS_SIZE:0] LP_MEMSIZE = (ADDRESS_SIZE + 1)'(MEMSIZE);

    logic [BITSIZE-1:0] r_mem [MEMSIZE];

    logic               w_wr_ok;
    logic               w_rd_ok;
    logic [BITSIZE-1:0] w_old;
    logic [BITSIZE-1:0] w_rd_word;

    logic               r_s1_valid;
    logic               r_s1_err;
    logic [BITSIZE-1:0] r_s1_data;

    assign w_wr_ok = write && (|wbe) && ({1'b0, wadrs} < LP_MEMSIZE);
    assign w_rd_ok = ({1'b0, radrs} < LP_MEMSIZE);
    assign w_old   = w_rd_ok ? r_mem[radrs] : '0;

`ifdef DPRAM_BYPASS_EN
    logic [BITSIZE-1:0] w_merged;

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < LANES; i++) begin
            if (wbe[i]) w_merged[i*LANE_WIDTH +: LANE_WIDTH] = wdata[i*LANE_WIDTH +: LANE_WIDTH];
        end
    end

    assign w_rd_word = (w_wr_ok && w_rd_ok && (wadrs == radrs)) ? w_merged : w_old;
`else
    assign w_rd_word = w_old;
`endif

    // Storage is deliberately never reset; writes are just masked off.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            for (int i = 0; i < LANES; i++) begin
                if (wbe[i]) r_mem[wadrs][i*LANE_WIDTH +: LANE_WIDTH] <= wdata[i*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    // First stage samples the array at the issue edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_data  <= '0;
        end else begin
            r_s1_valid <= read;
            r_s1_err   <= read & ~w_rd_ok;
            if (read) r_s1_data <= w_rd_word;
        end
    end

    dpram_rd_pipe #(
        .DEPTH (RD_LATENCY - 1),
        .WIDTH (BITSIZE)
    ) u_rd_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (r_s1_valid),
        .i_err   (r_s1_err),
        .i_data  (r_s1_data),
        .o_valid (rvalid),
        .o_err   (rerr),
        .o_data  (rdata)
    );

endmodule

// File: tb/tb_pipelined_dual_port_ram.sv
// Randomized self-checking bench for pipelined_dual_port_ram with a
// cycle-indexed behavioural reference model.
module tb_pipelined_dual_port_ram;

    localparam int BW = 32;
    localparam int LW = 8;
    localparam int NL = BW / LW;
    localparam int MS = 48;
    localparam int AW = 6;
    localparam int L  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          write;
    logic [NL-1:0] wbe;
    logic [AW-1:0] wadrs;
    logic [BW-1:0] wdata;
    logic          read;
    logic [AW-1:0] radrs;
    logic [BW-1:0] rdata;
    logic          rvalid;
    logic          rerr;

    pipelined_dual_port_ram #(
        .BITSIZE      (BW),
        .LANE_WIDTH   (LW),
        .MEMSIZE      (MS),
        .ADDRESS_SIZE (AW),
        .RD_LATENCY   (L)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .write  (write),
        .wbe    (wbe),
        .wadrs  (wadrs),
        .wdata  (wdata),
        .read   (read),
        .radrs  (radrs),
        .rdata  (rdata),
        .rvalid (rvalid),
        .rerr   (rerr)
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: memory array plus a schedule of results keyed by
    // the edge on which they must appear.
    logic [BW-1:0] m_mem [MS];
    logic          s_vld [8];
    logic          s_err [8];
    logic [BW-1:0] s_dat [8];
    int            cyc = 0;
    logic          e_valid;
    logic          e_err;
    logic [BW-1:0] e_data;
    logic [BW-1:0] last_data = '0;

    function automatic logic [BW-1:0] merge(input logic [BW-1:0] old,
                                            input logic [BW-1:0] nw,
                                            input logic [NL-1:0] be);
        logic [BW-1:0] m;
        m = old;
        for (int i = 0; i < NL; i++)
            if (be[i]) m[i*LW +: LW] = nw[i*LW +: LW];
        return m;
    endfunction

    task automatic model();
        int slot;
        int now;
        logic [BW-1:0] word;
        if (rst) begin
            for (int k = 0; k < 8; k++) s_vld[k] = 1'b0;
            e_valid   = 1'b0;
            e_err     = 1'b0;
            e_data    = '0;
            last_data = '0;
        end else begin
            if (read) begin
                slot = (cyc + L - 1) % 8;
                s_vld[slot] = 1'b1;
                if (int'(radrs) >= MS) begin
                    s_err[slot] = 1'b1;
                    s_dat[slot] = '0;
                end else begin
                    word = m_mem[radrs];
`ifdef DPRAM_BYPASS_EN
                    if (write && wadrs == radrs) word = merge(word, wdata, wbe);
`endif
                    s_err[slot] = 1'b0;
                    s_dat[slot] = word;
                end
            end
            if (write && int'(wadrs) < MS) m_mem[wadrs] = merge(m_mem[wadrs], wdata, wbe);
            now = cyc % 8;
            if (s_vld[now]) begin
                e_valid    = 1'b1;
                e_err      = s_err[now];
                e_data     = s_dat[now];
                last_data  = s_dat[now];
                s_vld[now] = 1'b0;
            end else begin
                e_valid = 1'b0;
                e_err   = 1'b0;
                e_data  = last_data;
            end
        end
        cyc++;
    endtask

    task automatic step(input logic w, input logic [NL-1:0] be, input logic [AW-1:0] wa,
                        input logic [BW-1:0] wd, input logic r, input logic [AW-1:0] ra,
                        input logic rs);
        write = w;
        wbe   = be;
        wadrs = wa;
        wdata = wd;
        read  = r;
        radrs = ra;
        rst   = rs;
        @(posedge clk);
        model();
        @(negedge clk);
        chk("rvalid", BW'(rvalid), BW'(e_valid));
        chk("rerr", BW'(rerr), BW'(e_err));
        chk("rdata", rdata, e_data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic lit(input string tag, input logic [BW-1:0] exp, input logic er);
        chk({tag, "_v"}, BW'(rvalid), BW'(1));
        chk({tag, "_e"}, BW'(rerr), BW'(er));
        chk({tag, "_d"}, rdata, exp);
    endtask

    logic [BW-1:0] save2;
    logic [BW-1:0] save0;

    initial begin
        for (int k = 0; k < 8; k++) begin
            s_vld[k] = 1'b0;
            s_err[k] = 1'b0;
            s_dat[k] = '0;
        end
        for (int a = 0; a < MS; a++) m_mem[a] = '0;

        // Reset, with a read and write attempted during reset.
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        step(1'b1, 4'hF, 6'd3, 32'h12345678, 1'b1, 6'd3, 1'b1);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        chk("reset_rdata", rdata, '0);

        // Fill all words so the model and array agree.
        for (int a = 0; a < MS; a++)
            step(1'b1, 4'hF, AW'(a), (a == 7) ? 32'h0 : BW'($urandom), 1'b0, '0, 1'b0);

        // Full write then read.
        step(1'b1, 4'hF, 6'd5, 32'hDEADBEEF, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b0);
        idle(L - 1);
        lit("full_wr", 32'hDEADBEEF, 1'b0);
        idle(1);
        chk("one_shot", BW'(rvalid), '0);

        // Partial lane write.
        step(1'b1, 4'h5, 6'd5, 32'h11223344, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd5, 1'b0);
        idle(L - 1);
        lit("lanes", 32'hDE22BE44, 1'b0);

        // Same-cycle read/write of one address.
        step(1'b1, 4'hF, 6'd7, 32'hAAAAAAAA, 1'b1, 6'd7, 1'b0);
        idle(L - 1);
`ifdef DPRAM_BYPASS_EN
        lit("same_cyc", 32'hAAAAAAAA, 1'b0);
`else
        lit("same_cyc", 32'h00000000, 1'b0);
`endif

        // Out-of-range read and write; no aliasing onto 50 mod 48.
        save2 = m_mem[2];
        step(1'b0, '0, '0, '0, 1'b1, 6'd50, 1'b0);
        idle(L - 1);
        lit("oor_rd", 32'h0, 1'b1);
        step(1'b1, 4'hF, 6'd50, 32'h55667788, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd2, 1'b0);
        idle(L - 1);
        lit("no_alias", save2, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd47, 1'b0);
        idle(L - 1);
        lit("last_word", m_mem[47], 1'b0);

        // Back-to-back reads cut short by reset.
        save0 = m_mem[0];
        step(1'b0, '0, '0, '0, 1'b1, 6'd0, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd1, 1'b0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd2, 1'b0);
        step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1);
        idle(3);
        chk("no_vld_after_rst", BW'(rvalid), '0);
        step(1'b0, '0, '0, '0, 1'b1, 6'd0, 1'b0);
        idle(L - 1);
        lit("kept_mem", save0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            wa = AW'($urandom_range(0, 63));
            ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 63));
            step(1'($urandom_range(0, 1)), NL'($urandom), wa, BW'($urandom),
                 1'($urandom_range(0, 1)), ra, ($urandom_range(0, 59) == 0));
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
